// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter onto a single request/acknowledge memory port with timeout.
// Optional build macro MEM_ARB_RR_EN: round-robin on simultaneous requests instead of fixed dm priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int  CNT_W  = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 32'sd1) : 32'sd1;
    localparam bit  TMO_EN = (TIMEOUT > 32'sd0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic [CNT_W-1:0] tmo_nxt_s;
    logic             tmo_hit_s;
    logic             grant_dm_s;
`ifdef MEM_ARB_RR_EN
    logic             last_dm_r;
`endif

    // Grant selection for the IDLE state
    always_comb begin
        grant_dm_s = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (if_req && dm_req) begin
            grant_dm_s = ~last_dm_r;
        end else if (dm_req) begin
            grant_dm_s = 1'b1;
        end else begin
            grant_dm_s = 1'b0;
        end
`else
        if (dm_req) begin
            grant_dm_s = 1'b1;
        end else begin
            grant_dm_s = 1'b0;
        end
`endif
    end

    // Timeout detection: this BUSY cycle without ack would be the TIMEOUT-th one
    always_comb begin
        tmo_nxt_s = tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        tmo_hit_s = 1'b0;
        if (TMO_EN && (tmo_nxt_s == CNT_W'(TIMEOUT))) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Main FSM with registered memory-side and requester-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            tmo_cnt_r <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            bus_err   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_dm_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (if_req || dm_req) begin
                        tmo_cnt_r <= '0;
                        mem_req   <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_dm_r <= grant_dm_s;
`endif
                        if (grant_dm_s) begin
                            state_r   <= BUSY_DM;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end else begin
                            state_r   <= BUSY_IF;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    // An ack arriving on the timeout cycle still completes normally
                    if (mem_ack || tmo_hit_s) begin
                        state_r <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= ~mem_ack;
                        if (state_r == BUSY_IF) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            dm_valid <= 1'b1;
                            if (!mem_ack) begin
                                dm_rdata <= '0;
                            end else if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end else begin
                                dm_rdata <= dm_rdata;
                            end
                        end
                    end else begin
                        tmo_cnt_r <= tmo_nxt_s;
                    end
                end
                RESP: begin
                    state_r  <= IDLE;
                    if_valid <= 1'b0;
                    dm_valid <= 1'b0;
                    bus_err  <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    if_valid <= 1'b0;
                    dm_valid <= 1'b0;
                    bus_err  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus hand-written arbitration,
// timeout, reset and stray-ack sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [8:0]  if_addr, dm_addr;
    logic [31:0] dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_wdata;
    logic        if_valid, dm_valid, bus_err, mem_req, mem_we;
    logic [8:0]  mem_addr;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          busy;
        logic [31:0] rdata;
        logic        drop;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_dm_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_mem_req"}, {63'd0, mem_req}, 64'd0);
        chk({name, "_mem_we"}, {63'd0, mem_we}, 64'd0);
        chk({name, "_if_valid"}, {63'd0, if_valid}, 64'd0);
        chk({name, "_dm_valid"}, {63'd0, dm_valid}, 64'd0);
        chk({name, "_bus_err"}, {63'd0, bus_err}, 64'd0);
    endtask

    task automatic run_txn(input vec_t v);
        @(negedge clk);
        if_req = ~v.is_dm; dm_req = v.is_dm; dm_we = v.we;
        if_addr = v.addr; dm_addr = v.addr; dm_wdata = v.wdata;
        mem_ack = 1'b0; mem_rdata = v.rdata;
        for (int c = 1; c <= v.busy; c++) begin
            @(negedge clk);
            chk("busy_mem_req", {63'd0, mem_req}, 64'd1);
            chk("busy_mem_we", {63'd0, mem_we}, {63'd0, v.we});
            if (c == 1) begin
                chk("busy_mem_addr", {55'd0, mem_addr}, {55'd0, v.addr});
                if (v.we) chk("busy_mem_wdata", {32'd0, mem_wdata}, {32'd0, v.wdata});
                if (v.drop) begin
                    if_req = 1'b0; dm_req = 1'b0;
                end
            end
            mem_ack = (c == v.busy);
        end
        @(negedge clk);
        mem_ack = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        chk("resp_mem_req", {63'd0, mem_req}, 64'd0);
        chk("resp_mem_we", {63'd0, mem_we}, 64'd0);
        chk("resp_if_valid", {63'd0, if_valid}, {63'd0, ~v.is_dm});
        chk("resp_dm_valid", {63'd0, dm_valid}, {63'd0, v.is_dm});
        chk("resp_bus_err", {63'd0, bus_err}, 64'd0);
        chk("resp_if_rdata", {32'd0, if_rdata}, {32'd0, v.exp_if_rdata});
        chk("resp_dm_rdata", {32'd0, dm_rdata}, {32'd0, v.exp_dm_rdata});
        @(negedge clk);
        chk_idle_outputs("post_resp");
    endtask

    initial begin
        logic [8:0] exp_addr[4];
        logic       exp_dm[4];
        int         busy_cnt;
        int         w;

        vecs[0] = '{1'b0, 1'b0, 9'h004, 32'h0,        1, 32'h00500093, 1'b0, 32'h00500093, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 9'h020, 32'h0,        2, 32'h12345678, 1'b0, 32'h00500093, 32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 3, 32'hFFFFFFFF, 1'b0, 32'h00500093, 32'h12345678};
        vecs[3] = '{1'b0, 1'b0, 9'h1FF, 32'h0,        1, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 9'h000, 32'h0,        4, 32'hA5A5A5A5, 1'b1, 32'hCAFEF00D, 32'hA5A5A5A5};

`ifdef MEM_ARB_RR_EN
        exp_dm = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int t = 0; t < 4; t++) exp_addr[t] = exp_dm[t] ? 9'h155 : 9'h0AA;

        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        if_addr = 9'h0; dm_addr = 9'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_mem_addr", {55'd0, mem_addr}, 64'd0);
        chk("reset_if_rdata", {32'd0, if_rdata}, 64'd0);
        chk("reset_dm_rdata", {32'd0, dm_rdata}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Simultaneous requests held across four transactions
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; if_addr = 9'h0AA; dm_addr = 9'h155;
        for (int t = 0; t < 4; t++) begin
            w = 0;
            @(negedge clk);
            while (!mem_req && w < 8) begin
                @(negedge clk);
                w++;
            end
            chk("arb_mem_req_seen", {63'd0, mem_req}, 64'd1);
            chk("arb_grant_addr", {55'd0, mem_addr}, {55'd0, exp_addr[t]});
            mem_ack = 1'b1; mem_rdata = 32'h10000000 + t;
            @(negedge clk);
            mem_ack = 1'b0;
            chk("arb_dm_valid", {63'd0, dm_valid}, {63'd0, exp_dm[t]});
            chk("arb_if_valid", {63'd0, if_valid}, {63'd0, ~exp_dm[t]});
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);

        // Load that is never acknowledged
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h033; mem_rdata = 32'h55555555;
        busy_cnt = 0;
        @(negedge clk);
        while (mem_req && busy_cnt < 40) begin
            busy_cnt++;
            @(negedge clk);
        end
        dm_req = 1'b0;
        chk("tmo_busy_cycles", busy_cnt, 64'd16);
        chk("tmo_dm_valid", {63'd0, dm_valid}, 64'd1);
        chk("tmo_bus_err", {63'd0, bus_err}, 64'd1);
        chk("tmo_dm_rdata", {32'd0, dm_rdata}, 64'd0);
        @(negedge clk);
        chk_idle_outputs("tmo_after");

        // Reset while a fetch is in flight
        if_req = 1'b1; if_addr = 9'h044;
        @(negedge clk);
        chk("rst_busy_mem_req", {63'd0, mem_req}, 64'd1);
        reset = 1'b1; if_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk_idle_outputs("rst_busy");
        chk("rst_busy_mem_addr", {55'd0, mem_addr}, 64'd0);
        chk("rst_busy_if_rdata", {32'd0, if_rdata}, 64'd0);
        chk("rst_busy_dm_rdata", {32'd0, dm_rdata}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_after_if_valid", {63'd0, if_valid}, 64'd0);
        end

        // Stray acknowledge in IDLE
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_idle_outputs("stray_ack");
            chk("stray_if_rdata", {32'd0, if_rdata}, 64'd0);
            chk("stray_dm_rdata", {32'd0, dm_rdata}, 64'd0);
        end
        mem_ack = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, giving the word address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, giving the maximum BUSY cycles before abort; 0 disables the timeout.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-005 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-high reset.
- if_req  in  1  instruction-fetch read request; held until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data.
- if_valid  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data-memory request; held until dm_valid.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data.
- dm_valid  out  1  one-cycle data completion pulse.
- bus_err  out  1  pulses with if_valid/dm_valid when the transaction timed out.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1.
- mem_ack  in  1  memory completion; may be asserted in the first mem_req cycle.

Function
REQ-006 The FSM SHALL have the states IDLE, BUSY_IF, BUSY_DM and RESP.
REQ-007 In IDLE with exactly one request pending, the FSM SHALL grant that request at the next edge; with both pending, dm SHALL win.
REQ-008 On grant, the block SHALL register address, we (0 for fetch) and wdata, and drive them on mem_* with mem_req=1 throughout BUSY_x.
REQ-009 mem_* outputs SHALL be registered; outside BUSY_x, mem_req=0 and mem_we=0.
REQ-010 In BUSY_x, mem_ack=1 SHALL capture mem_rdata (loads and fetches only) and move the FSM to RESP.
REQ-011 In RESP, the granted requester's x_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-012 Minimum latency SHALL be: req seen in IDLE at cycle 0, mem_req at cycle 1 with ack, x_valid at cycle 2; the next grant is possible at cycle 3.
REQ-013 x_rdata SHALL hold its value until the next completion for the same requester; a store SHALL leave dm_rdata unchanged.
REQ-014 The timeout counter SHALL clear on grant, increment each BUSY cycle without mem_ack, and on reaching TIMEOUT force RESP with bus_err=1 and x_rdata=0.
REQ-015 mem_ack in IDLE or RESP SHALL be ignored.
REQ-016 Deassertion of the granted req mid-transaction SHALL be ignored; the transaction SHALL complete and x_valid SHALL still pulse.
REQ-017 Request inputs SHALL be sampled only in IDLE, so requests arriving during BUSY_x or RESP SHALL wait.

Reset
REQ-018 On reset the block SHALL set state to IDLE; mem_req, mem_we, if_valid, dm_valid and bus_err to 0; mem_addr, mem_wdata, if_rdata, dm_rdata and the timeout counter to 0; and the last-grant flag to IF.
REQ-019 Reset mid-transaction SHALL abort it with no valid pulse, and mem_req SHALL be 0 from the first cycle after the reset edge.

Configuration
REQ-020 When MEM_ARB_RR_EN is defined, simultaneous requests SHALL be granted round-robin, to the requester not granted last.
REQ-021 When MEM_ARB_RR_EN is defined, the last-grant flag SHALL update on every grant.
REQ-022 When MEM_ARB_RR_EN is undefined, fixed dm priority SHALL apply and the last-grant flag SHALL be absent.

Verification
REQ-023 The bench SHALL check a single fetch: if_req=1, if_addr=0x004, mem_ack in the first BUSY cycle with mem_rdata=0x00500093 -> mem_req=1 and mem_addr=0x004 at cycle 1; if_valid=1 and if_rdata=0x00500093 at cycle 2.
REQ-024 The bench SHALL check a store with wait states: dm_we=1, dm_addr=0x010, dm_wdata=0xDEADBEEF, mem_ack delayed 3 cycles -> mem_we=1 held for 3 cycles; dm_valid pulses once; dm_rdata unchanged.
REQ-025 The bench SHALL check simultaneous if_req and dm_req held for 4 transactions -> without MEM_ARB_RR_EN the grants are DM,DM,DM,DM; with MEM_ARB_RR_EN they are DM,IF,DM,IF.
REQ-026 The bench SHALL check a timeout: with TIMEOUT=16 and mem_ack never asserted -> after 16 BUSY cycles, dm_valid=1, bus_err=1, dm_rdata=0, then IDLE.
REQ-027 The bench SHALL check reset in BUSY_IF -> no if_valid, mem_req=0 the next cycle, all outputs at reset values.
REQ-028 The bench SHALL check a stray mem_ack=1 in IDLE -> no valid pulse and no change to the rdata registers.
